pipeline_biss_arb: RTL and testbench

PIPELINE_BISS_ARB -- requirements
Module: pipeline_biss_arb

---
 rtl/pipeline_biss_arb.sv | 108 ++++++++++
 tb/tb_pipeline_biss_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_biss_arb.sv
// pipeline_biss_arb: two-requester round-robin front end feeding a
// three-stage add pipeline with global stall, flush and completion counters.
module pipeline_biss_arb #(
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          flush,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_id,
  input  logic          out_ready,
  output logic          busy,
  output logic [CW-1:0] done0_cnt,
  output logic [CW-1:0] done1_cnt
);

  typedef struct packed {
    logic          v;
    logic          id;
    logic [DW-1:0] d;
  } stg_t;

  stg_t          s1, s2, s3;
  logic          ptr;
  logic          adv;
  logic          gnt;
  logic          acc;
  logic          xfer;
  logic [DW-1:0] in_d;

  // Round-robin grant: alternate on contention, else the lone requester.
  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid)
      gnt = ~ptr;
    else
      gnt = req1_valid;
  end

  // Handshake: whole pipe advances together; flush and reset block accepts.
  always_comb begin
    adv        = !s3.v || out_ready;
    xfer       = s3.v && out_ready;
    req0_ready = !rst && adv && !flush
               && req0_valid && !gnt;
    req1_ready = !rst && adv && !flush
               && req1_valid && gnt;
    acc        = req0_ready || req1_ready;
    in_d       = gnt ? req1_data : req0_data;
  end

  // Stage registers and last-grant pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      s3  <= '0;
      ptr <= 1'b1;
    end else begin
      if (acc)
        ptr <= gnt;
      if (flush) begin
        s1.v <= 1'b0;
        s2.v <= 1'b0;
        s3.v <= 1'b0;
      end else if (adv) begin
        s3.v  <= s2.v;
        s3.id <= s2.id;
        s3.d  <= s2.d + DW'(1000);
        s2.v  <= s1.v;
        s2.id <= s1.id;
        s2.d  <= s1.d + DW'(100);
        s1.v  <= acc;
        if (acc) begin
          s1.id <= gnt;
          s1.d  <= in_d + DW'(10);
        end
      end
    end
  end

  // Completion counters bump on every result transfer, flush or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done0_cnt <= '0;
      done1_cnt <= '0;
    end else if (xfer) begin
      if (s3.id)
        done1_cnt <= done1_cnt + CW'(1);
      else
        done0_cnt <= done0_cnt + CW'(1);
    end
  end

  assign out_valid = s3.v;
  assign out_data  = s3.d;
  assign out_id    = s3.id;
  assign busy      = s1.v || s2.v || s3.v;

endmodule

// File: tb/tb_pipeline_biss_arb.sv
// tb_pipeline_biss_arb: directed vectors with hand-computed results
// for arbitration, latency, stall, wrap, flush and async reset.
module tb_pipeline_biss_arb;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        flush;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_id;
  logic        out_ready;
  logic        busy;
  logic [7:0]  done0_cnt, done1_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] c_exp [4];
  logic        c_id  [4];

  pipeline_biss_arb #(.DW(16), .CW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .busy       (busy),
    .done0_cnt  (done0_cnt),
    .done1_cnt  (done1_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    req0_data = '0;
    req1_data = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_done0", done0_cnt, 0);
    chk("rst_done1", done1_cnt, 0);
    chk("rst_ready0", req0_ready, 0);
    req0_valid = 1'b0;
    step();
    rst = 1'b0;

    // single op
    req0_valid = 1'b1;
    req0_data = 16'd5;
    out_ready = 1'b1;
    #1;
    chk("single_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    chk("single_busy", busy, 1);
    step();
    chk("single_early", out_valid, 0);
    step();
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 1115);
    chk("single_id", out_id, 0);
    step();
    chk("single_done0", done0_cnt, 1);
    chk("single_drain", out_valid, 0);

    // restore pointer to 1 and clear counters
    pulse_rst();
    chk("arst_cnt", done0_cnt, 0);

    // contention
    c_exp[0] = 16'd1111; c_id[0] = 1'b0;
    c_exp[1] = 16'd1112; c_id[1] = 1'b1;
    c_exp[2] = 16'd1111; c_id[2] = 1'b0;
    c_exp[3] = 16'd1112; c_id[3] = 1'b1;
    req0_data = 16'd1;
    req1_data = 16'd2;
    for (int j = 1; j <= 7; j++) begin
      if (j <= 4) begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rr_ready0", req0_ready, (j % 2));
        chk("rr_ready1", req1_ready, 1 - (j % 2));
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      step();
      if (j >= 3 && j <= 6) begin
        chk("rr_valid", out_valid, 1);
        chk("rr_data", out_data, c_exp[j-3]);
        chk("rr_id", out_id, c_id[j-3]);
      end
    end
    chk("rr_drain", out_valid, 0);
    chk("rr_done0", done0_cnt, 2);
    chk("rr_done1", done1_cnt, 2);

    // backpressure
    out_ready = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_data = 16'(20 + i);
      step();
    end
    req0_data = 16'd23;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready0", req0_ready, 0);
      chk("bp_data", out_data, 1130);
      chk("bp_valid", out_valid, 1);
      step();
    end
    chk("bp_done0_held", done0_cnt, 2);
    req0_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_r1", out_data, 1131);
    step();
    chk("bp_r2", out_data, 1132);
    chk("bp_r2v", out_valid, 1);
    step();
    chk("bp_drain", out_valid, 0);
    chk("bp_done0", done0_cnt, 5);

    // modulo wrap, operand 0 is a real op
    req1_valid = 1'b1;
    req1_data = 16'hFFFF;
    step();
    req1_data = 16'h0000;
    step();
    req1_valid = 1'b0;
    step();
    chk("wrap_data0", out_data, 16'h0455);
    chk("wrap_id", out_id, 1);
    step();
    chk("wrap_valid1", out_valid, 1);
    chk("wrap_data1", out_data, 16'h0456);
    step();
    chk("wrap_done1", done1_cnt, 4);

    // flush with stalled full pipe
    out_ready = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req0_data = 16'(7 + i);
      step();
    end
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl_ready0", req0_ready, 0);
    out_ready = 1'b0;
    step();
    flush = 1'b0;
    req0_valid = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_done0", done0_cnt, 5);
    chk("fl_done1", done1_cnt, 4);
    step();
    chk("fl_after", busy, 0);

    // flush coinciding with a transfer still counts it
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    req0_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flx_done0", done0_cnt, 6);
    chk("flx_busy", busy, 0);

    // async reset with two ops in flight
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("ar_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_out_data", out_data, 0);
    chk("ar_done0", done0_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ar_no_out", out_valid, 0);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("ar_grant0", req0_ready, 1);
    chk("ar_grant1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
